// File: rtl/mem_wb_stage_buf_if.sv
// MEM -> WB stage bundle: upstream valid/ready, downstream valid/ready and payload fields.
// Optional performance counters appear only when MEM_WB_PERF_CNT_EN is defined.
interface mem_wb_stage_buf_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) ();
    // Handshake: a beat moves on a side when valid & ready are both high at the
    // rising clock edge; valid never depends on ready, and ready is registered.
    logic                  in_valid;
    logic                  in_ready;
    logic                  flush;
    logic                  reg_write_in;
    logic                  mem_to_reg_in;
    logic [DATA_W-1:0]     read_data_in;
    logic [DATA_W-1:0]     alu_result_in;
    logic [REG_ADDR_W-1:0] write_reg_in;

    logic                  out_valid;
    logic                  out_ready;
    logic                  reg_write_out;
    logic                  mem_to_reg_out;
    logic [DATA_W-1:0]     read_data_out;
    logic [DATA_W-1:0]     alu_result_out;
    logic [REG_ADDR_W-1:0] write_reg_out;
    logic [DATA_W-1:0]     wb_data_out;
    logic [1:0]            state_dbg;
`ifdef MEM_WB_PERF_CNT_EN
    logic [DATA_W-1:0]     retired_cnt_out;
    logic [DATA_W-1:0]     stall_cnt_out;
`endif

    modport slave (
        input  in_valid, flush, reg_write_in, mem_to_reg_in,
               read_data_in, alu_result_in, write_reg_in, out_ready,
        output in_ready, out_valid, reg_write_out, mem_to_reg_out,
               read_data_out, alu_result_out, write_reg_out, wb_data_out,
`ifdef MEM_WB_PERF_CNT_EN
               retired_cnt_out, stall_cnt_out,
`endif
               state_dbg
    );

    modport master (
        output in_valid, flush, reg_write_in, mem_to_reg_in,
               read_data_in, alu_result_in, write_reg_in, out_ready,
        input  in_ready, out_valid, reg_write_out, mem_to_reg_out,
               read_data_out, alu_result_out, write_reg_out, wb_data_out,
`ifdef MEM_WB_PERF_CNT_EN
               retired_cnt_out, stall_cnt_out,
`endif
               state_dbg
    );
endinterface

// File: rtl/mem_wb_stage_buf.sv
// MEM/WB pipeline register with a 2-entry skid buffer, flush and write-back data select.
// Define MEM_WB_PERF_CNT_EN to add retired/stall counters.
module mem_wb_stage_buf #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    mem_wb_stage_buf_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [DATA_W-1:0]     read_data;
        logic [DATA_W-1:0]     alu_result;
        logic [REG_ADDR_W-1:0] write_reg;
    } entry_t;

    state_t state;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;
    logic   in_ready_q;
    logic   out_valid_q;
    logic   accept;
    logic   pop;

    assign in_entry = '{reg_write:  bus.reg_write_in,
                        mem_to_reg: bus.mem_to_reg_in,
                        read_data:  bus.read_data_in,
                        alu_result: bus.alu_result_in,
                        write_reg:  bus.write_reg_in};

    assign accept = bus.in_valid & in_ready_q;
    assign pop    = out_valid_q & bus.out_ready;

    // in_ready/out_valid are kept as registers that track the next state directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
        end else if (bus.flush) begin
            state            <= EMPTY;
            in_ready_q       <= 1'b1;
            out_valid_q      <= 1'b0;
            main_q.reg_write <= 1'b0;
            skid_q.reg_write <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state       <= ONE;
                        out_valid_q <= 1'b1;
                        main_q      <= in_entry;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_q <= in_entry;
                    end else if (accept) begin
                        state      <= TWO;
                        in_ready_q <= 1'b0;
                        skid_q     <= in_entry;
                    end else if (pop) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state      <= ONE;
                        in_ready_q <= 1'b1;
                        main_q     <= skid_q;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.reg_write_out  = main_q.reg_write & out_valid_q;
    assign bus.mem_to_reg_out = main_q.mem_to_reg;
    assign bus.read_data_out  = main_q.read_data;
    assign bus.alu_result_out = main_q.alu_result;
    assign bus.write_reg_out  = main_q.write_reg;
    assign bus.wb_data_out    = main_q.mem_to_reg ? main_q.read_data : main_q.alu_result;
    assign bus.state_dbg      = state;

`ifdef MEM_WB_PERF_CNT_EN
    logic [DATA_W-1:0] retired_cnt_q;
    logic [DATA_W-1:0] stall_cnt_q;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            if (pop && bus.reg_write_out) begin
                retired_cnt_q <= retired_cnt_q + 1'b1;
            end
            if (bus.in_valid && !in_ready_q) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign bus.retired_cnt_out = retired_cnt_q;
    assign bus.stall_cnt_out   = stall_cnt_q;
`endif
endmodule

// File: tb/tb_mem_wb_stage_buf.sv
// Directed bench for mem_wb_stage_buf: reset, streaming, skid, flush, reset priority
// and, with MEM_WB_PERF_CNT_EN, the performance counters.
module tb_mem_wb_stage_buf;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    mem_wb_stage_buf_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

    mem_wb_stage_buf #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic rw, input logic m2r, input logic [31:0] rd,
                        input logic [31:0] alu, input logic [4:0] wr);
        bus.in_valid      = 1'b1;
        bus.reg_write_in  = rw;
        bus.mem_to_reg_in = m2r;
        bus.read_data_in  = rd;
        bus.alu_result_in = alu;
        bus.write_reg_in  = wr;
    endtask

    task automatic idle();
        bus.in_valid      = 1'b0;
        bus.reg_write_in  = 1'($urandom_range(0, 1));
        bus.mem_to_reg_in = 1'($urandom_range(0, 1));
        bus.read_data_in  = $urandom;
        bus.alu_result_in = $urandom;
        bus.write_reg_in  = 5'($urandom_range(0, 31));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_in_ready"},  64'(bus.in_ready), 64'd1);
        chk({tag, "_reg_write"}, 64'(bus.reg_write_out), 64'd0);
        chk({tag, "_mem_to_reg"}, 64'(bus.mem_to_reg_out), 64'd0);
        chk({tag, "_read_data"}, 64'(bus.read_data_out), 64'd0);
        chk({tag, "_alu"},       64'(bus.alu_result_out), 64'd0);
        chk({tag, "_write_reg"}, 64'(bus.write_reg_out), 64'd0);
        chk({tag, "_wb_data"},   64'(bus.wb_data_out), 64'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        // Reset with random, valid-looking inputs
        rst = 1'b1;
        bus.flush     = 1'($urandom_range(0, 1));
        bus.out_ready = 1'($urandom_range(0, 1));
        send(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 31)));
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        bus.flush = 1'b0;
        idle();
        tick();

        // Streaming at full throughput
        bus.out_ready = 1'b1;
        send(1'b1, 1'b0, 32'h0000_0AAA, 32'h10, 5'd5);
        tick();
        chk("s1_valid", 64'(bus.out_valid), 64'd1);
        chk("s1_wb", 64'(bus.wb_data_out), 64'h10);
        chk("s1_wr", 64'(bus.write_reg_out), 64'd5);
        chk("s1_rw", 64'(bus.reg_write_out), 64'd1);
        chk("s1_ready", 64'(bus.in_ready), 64'd1);
        send(1'b1, 1'b0, 32'h0000_0BBB, 32'h20, 5'd6);
        tick();
        chk("s2_wb", 64'(bus.wb_data_out), 64'h20);
        chk("s2_wr", 64'(bus.write_reg_out), 64'd6);
        chk("s2_ready", 64'(bus.in_ready), 64'd1);
        send(1'b1, 1'b0, 32'h0000_0CCC, 32'h30, 5'd7);
        tick();
        chk("s3_wb", 64'(bus.wb_data_out), 64'h30);
        chk("s3_wr", 64'(bus.write_reg_out), 64'd7);
        chk("s3_ready", 64'(bus.in_ready), 64'd1);
        // Bit-exact load data with destination 0
        send(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1234, 5'd0);
        tick();
        chk("bx_wb", 64'(bus.wb_data_out), 64'hFFFF_FFFF);
        chk("bx_wr", 64'(bus.write_reg_out), 64'd0);
        chk("bx_rw", 64'(bus.reg_write_out), 64'd0);
        chk("bx_m2r", 64'(bus.mem_to_reg_out), 64'd1);
        idle();
        tick();
        chk("s_drain_valid", 64'(bus.out_valid), 64'd0);
        chk("s_drain_rw", 64'(bus.reg_write_out), 64'd0);

        // Skid: fill both entries under backpressure
        bus.out_ready = 1'b0;
        send(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h111, 5'd8);
        tick();
        chk("k_a_wb", 64'(bus.wb_data_out), 64'hDEAD_BEEF);
        chk("k_a_ready", 64'(bus.in_ready), 64'd1);
        send(1'b1, 1'b0, 32'h222, 32'h4, 5'd9);
        tick();
        chk("k_b_ready", 64'(bus.in_ready), 64'd0);
        chk("k_b_wb", 64'(bus.wb_data_out), 64'hDEAD_BEEF);
        chk("k_b_state", 64'(bus.state_dbg), 64'd2);
        send(1'b1, 1'b0, 32'h333, 32'hC, 5'd10);
        tick();
        chk("k_c_ready", 64'(bus.in_ready), 64'd0);
        chk("k_c_wr", 64'(bus.write_reg_out), 64'd8);
        idle();
        bus.out_ready = 1'b1;
        tick();
        chk("k_popa_wb", 64'(bus.wb_data_out), 64'h4);
        chk("k_popa_wr", 64'(bus.write_reg_out), 64'd9);
        chk("k_popa_ready", 64'(bus.in_ready), 64'd1);
        tick();
        chk("k_popb_valid", 64'(bus.out_valid), 64'd0);

        // Flush while full, with a new input offered
        bus.out_ready = 1'b0;
        send(1'b1, 1'b0, 32'h0, 32'h51, 5'd1);
        tick();
        send(1'b1, 1'b0, 32'h0, 32'h52, 5'd2);
        tick();
        chk("f_full_ready", 64'(bus.in_ready), 64'd0);
        send(1'b1, 1'b0, 32'h0, 32'h53, 5'd3);
        bus.flush = 1'b1;
        tick();
        chk("f_valid", 64'(bus.out_valid), 64'd0);
        chk("f_rw", 64'(bus.reg_write_out), 64'd0);
        chk("f_ready", 64'(bus.in_ready), 64'd1);
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        idle();
        tick();
        chk("f_after_valid", 64'(bus.out_valid), 64'd0);
        // Flush in ONE discards an input accepted on the same edge
        send(1'b1, 1'b0, 32'h0, 32'h61, 5'd11);
        tick();
        chk("f1_wb", 64'(bus.wb_data_out), 64'h61);
        send(1'b1, 1'b0, 32'h0, 32'h62, 5'd12);
        bus.flush = 1'b1;
        tick();
        chk("f1_valid", 64'(bus.out_valid), 64'd0);
        chk("f1_rw", 64'(bus.reg_write_out), 64'd0);
        bus.flush = 1'b0;
        idle();
        tick();
        chk("f1_after_valid", 64'(bus.out_valid), 64'd0);

        // Reset beats flush and accept
        bus.out_ready = 1'b0;
        send(1'b1, 1'b0, 32'h0, 32'h71, 5'd13);
        tick();
        chk("rp_pre_valid", 64'(bus.out_valid), 64'd1);
        send(1'b1, 1'b1, 32'h99, 32'h72, 5'd14);
        rst = 1'b1;
        bus.flush = 1'b1;
        tick();
        chk_reset_outputs("rprio");
        rst = 1'b0;
        bus.flush = 1'b0;
        idle();
        tick();
        chk("rp_after_valid", 64'(bus.out_valid), 64'd0);
        chk("rp_after_ready", 64'(bus.in_ready), 64'd1);

`ifdef MEM_WB_PERF_CNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("pc_rst_ret", 64'(bus.retired_cnt_out), 64'd0);
        chk("pc_rst_stall", 64'(bus.stall_cnt_out), 64'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 1'b0, 32'h0, 32'(i), 5'(i + 1));
            tick();
        end
        send(1'b0, 1'b0, 32'h0, 32'h7, 5'd4);
        tick();
        idle();
        tick();
        chk("pc_ret", 64'(bus.retired_cnt_out), 64'd3);
        bus.out_ready = 1'b0;
        send(1'b1, 1'b0, 32'h0, 32'h8, 5'd5);
        tick();
        send(1'b1, 1'b0, 32'h0, 32'h9, 5'd6);
        tick();
        send(1'b1, 1'b0, 32'h0, 32'hA, 5'd7);
        tick();
        tick();
        idle();
        chk("pc_stall", 64'(bus.stall_cnt_out), 64'd2);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("pc_flush_ret", 64'(bus.retired_cnt_out), 64'd3);
        chk("pc_flush_stall", 64'(bus.stall_cnt_out), 64'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("pc_rst2_ret", 64'(bus.retired_cnt_out), 64'd0);
        chk("pc_rst2_stall", 64'(bus.stall_cnt_out), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
